// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode and ALU-function encodings shared by datapath, control and decode.
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADDS = 4'b0010,
    OP_SUBS = 4'b1011,
    OP_B    = 4'b0100,
    OP_CBZ  = 4'b0101,
    OP_BLT  = 4'b0110
  } opcode_t;
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;
  function automatic logic is_flag_op(input logic [3:0] op);
    return op == OP_ADDS || op == OP_SUBS;
  endfunction
endpackage

// File: rtl/alu64.sv
// alu64: combinational 64-bit ALU producing result and live NZVC flags.
module alu64
  import cpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  op,
  output logic [63:0] result,
  output logic        n,
  output logic        z,
  output logic        v,
  output logic        c
);
  logic        sub, arith;
  logic [63:0] bx;
  logic [64:0] sum;
  assign sub   = op == ALU_SUB;
  assign arith = op == ALU_ADD || sub;
  // Subtract is A + ~B + 1 so carry-out means "no borrow".
  assign bx  = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + 65'(sub);
  always_comb begin
    result = arith            ? sum[63:0] :
             op == ALU_PASS_B ? b :
             op == ALU_AND    ? a & b :
             op == ALU_OR     ? a | b :
             op == ALU_XOR    ? a ^ b : '0;
  end
  assign n = result[63];
  assign z = result == '0;
  assign v = arith && (a[63] == bx[63]) && (sum[63] != a[63]);
  assign c = arith && sum[64];
endmodule

// File: rtl/accel_branch_alu.sv
// accel_branch_alu: ALU, PC adders, decode-stage branch resolver and NZVC flag register.
module accel_branch_alu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_rf,
  input  logic [3:0]  opcode_rf,
  input  logic [18:0] imm19,
  input  logic [25:0] imm26,
  input  logic [63:0] db_rf,
  input  logic [3:0]  opcode_ex,
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  input  logic [2:0]  alu_op,
  output logic [63:0] alu_result,
  output logic        alu_n,
  output logic        alu_z,
  output logic        alu_v,
  output logic        alu_c,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_c,
  output logic [63:0] pc_plus4,
  output logic        br_taken,
  output logic [63:0] br_target
);
  logic        flag_set, eff_n, eff_v;
  logic [63:0] offset;
  alu64 u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result),
    .n(alu_n), .z(alu_z), .v(alu_v), .c(alu_c)
  );
  assign flag_set = is_flag_op(opcode_ex);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {flag_n, flag_z, flag_v, flag_c} <= '0;
    else if (flag_set) {flag_n, flag_z, flag_v, flag_c} <= {alu_n, alu_z, alu_v, alu_c};
  end
  // BLT in decode sees the flags an ADDS/SUBS in EX is about to write.
  assign eff_n = flag_set ? alu_n : flag_n;
  assign eff_v = flag_set ? alu_v : flag_v;
  assign offset = opcode_rf == OP_B ? {{36{imm26[25]}}, imm26, 2'b00}
                                    : {{43{imm19[18]}}, imm19, 2'b00};
  assign pc_plus4  = pc_rf + 64'd4;
  assign br_target = pc_rf + offset;
  always_comb begin
    br_taken = opcode_rf == OP_B   ? 1'b1 :
               opcode_rf == OP_CBZ ? db_rf == '0 :
               opcode_rf == OP_BLT ? eff_n ^ eff_v : 1'b0;
  end
endmodule

// File: tb/tb_accel_branch_alu.sv
// tb_accel_branch_alu: scoreboard bench checking ALU, branch resolver and flag register.
module tb_accel_branch_alu;
  logic        clk = 0, reset = 0;
  logic [63:0] pc_rf = 0, db_rf = 0, alu_a = 0, alu_b = 0;
  logic [3:0]  opcode_rf = 0, opcode_ex = 0;
  logic [18:0] imm19 = 0;
  logic [25:0] imm26 = 0;
  logic [2:0]  alu_op = 0;
  logic [63:0] alu_result, pc_plus4, br_target;
  logic        alu_n, alu_z, alu_v, alu_c, flag_n, flag_z, flag_v, flag_c, br_taken;
  int          errors = 0, checks = 0;
  logic [3:0]  m_flags;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  nzvc;
    logic        tk;
    logic [63:0] tgt;
    logic [63:0] p4;
  } exp_t;
  exp_t sb[$];

  accel_branch_alu dut (
    .clk(clk), .reset(reset), .pc_rf(pc_rf), .opcode_rf(opcode_rf), .imm19(imm19),
    .imm26(imm26), .db_rf(db_rf), .opcode_ex(opcode_ex), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .alu_c(alu_c), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c),
    .pc_plus4(pc_plus4), .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  function automatic exp_t model();
    exp_t e;
    logic signed [64:0] s;
    logic fs;
    logic [1:0] nv;
    e.nzvc = '0;
    s = '0;
    case (alu_op)
      3'b000: e.res = alu_b;
      3'b010: begin
        e.res = alu_a + alu_b;
        e.nzvc[0] = (128'(alu_a) + 128'(alu_b)) > 128'(64'hFFFF_FFFF_FFFF_FFFF);
        s = $signed({alu_a[63], alu_a}) + $signed({alu_b[63], alu_b});
      end
      3'b011: begin
        e.res = alu_a - alu_b;
        e.nzvc[0] = alu_a >= alu_b;
        s = $signed({alu_a[63], alu_a}) - $signed({alu_b[63], alu_b});
      end
      3'b100: e.res = alu_a & alu_b;
      3'b101: e.res = alu_a | alu_b;
      3'b110: e.res = alu_a ^ alu_b;
      default: e.res = '0;
    endcase
    e.nzvc[1] = s[64] != s[63];
    e.nzvc[3] = e.res[63];
    e.nzvc[2] = e.res == 0;
    fs = opcode_ex == 4'b0010 || opcode_ex == 4'b1011;
    nv = fs ? {e.nzvc[3], e.nzvc[1]} : {m_flags[3], m_flags[1]};
    e.p4  = pc_rf + 4;
    e.tgt = opcode_rf == 4'b0100 ? pc_rf + 64'($signed(imm26)) * 4
                                 : pc_rf + 64'($signed(imm19)) * 4;
    e.tk  = opcode_rf == 4'b0100 || (opcode_rf == 4'b0101 && db_rf == 0) ||
            (opcode_rf == 4'b0110 && nv[1] != nv[0]);
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_flags <= '0;
    else if (opcode_ex == 4'b0010 || opcode_ex == 4'b1011) m_flags <= model().nzvc;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic vec(input string tag);
    exp_t e;
    sb.push_back(model());
    #1;
    e = sb.pop_front();
    check_val({tag, ".res"}, alu_result, e.res);
    check_val({tag, ".nzvc"}, 64'({alu_n, alu_z, alu_v, alu_c}), 64'(e.nzvc));
    check_val({tag, ".taken"}, 64'(br_taken), 64'(e.tk));
    check_val({tag, ".target"}, br_target, e.tgt);
    check_val({tag, ".pc4"}, pc_plus4, e.p4);
  endtask

  function automatic logic [63:0] flags();
    return 64'({flag_n, flag_z, flag_v, flag_c});
  endfunction

  task automatic edge_check(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    check_val(tag, flags(), 64'(exp));
    check_val({tag, ".model"}, flags(), 64'(m_flags));
  endtask

  initial begin
    opcode_ex = 4'b1011; alu_op = 3'b011; alu_a = 3; alu_b = 3;
    repeat (2) @(posedge clk);
    #1 check_val("reset_hold", flags(), 0);
    @(negedge clk) reset = 1;
    edge_check("first_edge", 4'b0101);

    @(negedge clk) opcode_ex = 0; alu_op = 3'b010; alu_a = 64'h7FFF_FFFF_FFFF_FFFF; alu_b = 1;
    vec("add_ovf");
    check_val("add_ovf.const", alu_result, 64'h8000_0000_0000_0000);
    check_val("add_ovf.flags", 64'({alu_n, alu_z, alu_v, alu_c}), 64'(4'b1010));
    alu_op = 3'b011; alu_a = 0; alu_b = 1;
    vec("sub_borrow");
    check_val("sub_borrow.const", alu_result, '1);
    check_val("sub_borrow.nc", 64'({alu_n, alu_c}), 64'(2'b10));

    @(negedge clk) opcode_ex = 4'b0010; alu_op = 3'b010; alu_a = 64'h7FFF_FFFF_FFFF_FFFF; alu_b = 1;
    edge_check("adds_capture", 4'b1010);
    @(negedge clk) opcode_ex = 4'b1011; alu_op = 3'b011; alu_a = 5; alu_b = 5;
    edge_check("b2b_subs", 4'b0101);
    @(negedge clk) opcode_ex = 0; alu_a = 1; alu_b = 2;
    edge_check("flag_hold", 4'b0101);

    @(negedge clk) opcode_rf = 4'b0101; pc_rf = 64'h100; imm19 = 19'h7FFFE; db_rf = 0;
    vec("cbz_taken");
    check_val("cbz_taken.tk", 64'(br_taken), 1);
    check_val("cbz_taken.tgt", br_target, 64'hF8);
    db_rf = 1;
    vec("cbz_not");
    check_val("cbz_not.tk", 64'(br_taken), 0);
    check_val("cbz_not.pc4", pc_plus4, 64'h104);
    opcode_rf = 4'b0100; pc_rf = 64'h10; imm26 = 26'h3FFFFFF;
    vec("b_uncond");
    check_val("b_uncond.tk", 64'(br_taken), 1);
    check_val("b_uncond.tgt", br_target, 64'h0C);

    @(negedge clk) reset = 0;
    #2 check_val("async_clear", flags(), 0);
    @(negedge clk) reset = 1;
    opcode_rf = 4'b0110; opcode_ex = 4'b1011; alu_op = 3'b011; alu_a = 1; alu_b = 2;
    vec("blt_bypass");
    check_val("blt_bypass.tk", 64'(br_taken), 1);
    opcode_ex = 0;
    vec("blt_regflags");
    check_val("blt_regflags.tk", 64'(br_taken), 0);
    opcode_ex = 4'b1011;
    edge_check("blt_capture", 4'b1000);
    @(negedge clk) opcode_ex = 0; alu_a = 7; alu_b = 7;
    vec("blt_after");
    check_val("blt_after.tk", 64'(br_taken), 1);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      alu_op = 3'($urandom_range(0, 7));
      alu_a = {$urandom, $urandom};
      alu_b = i % 4 == 0 ? alu_a : {$urandom, $urandom};
      if (i % 5 == 1) alu_a = 64'h8000_0000_0000_0000;
      opcode_rf = 4'($urandom_range(0, 15));
      opcode_ex = i % 3 == 0 ? 4'b0010 : i % 3 == 1 ? 4'b1011 : 4'($urandom_range(0, 15));
      pc_rf = {$urandom, $urandom};
      imm19 = 19'($urandom); imm26 = 26'($urandom);
      db_rf = i % 2 == 0 ? 64'd0 : {$urandom, $urandom};
      vec($sformatf("rnd%0d", i));
      @(posedge clk);
      #1 check_val($sformatf("rnd%0d.flags", i), flags(), 64'(m_flags));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
